// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the schoolMIPS register dump unit.
// SM_REGDUMP_ADDR_EN adds a leading address byte to every dumped word.
package sm_regdump_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_SAMPLE = 2'd1,
        RD_SEND   = 2'd2
    } rd_state_t;

    localparam logic [4:0] RD_LAST_REG = 5'd31;

`ifdef SM_REGDUMP_ADDR_EN
    localparam int RD_BYTES = 5;
`else
    localparam int RD_BYTES = 4;
`endif

    localparam logic [2:0] RD_LAST_BYTE = 3'(RD_BYTES - 1);

    // Byte k of a word in transmit order: k=0 is bits 31:24.
    function automatic logic [7:0] rd_word_byte(input logic [31:0] word, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = word[31:24];
            3'd1:    b = word[23:16];
            3'd2:    b = word[15:8];
            3'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sm_regdump_uart_tx.sv
// Single-byte 8N1 transmitter. ready is also high in the last cycle of a
// stop bit so a chained go starts the next byte with no idle gap.
module sm_uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic        r_busy;
    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        w_bit_end;
    logic        w_byte_end;

    assign w_bit_end  = r_busy && (r_baud_cnt == BAUD_LAST);
    assign w_byte_end = w_bit_end && (r_bit_idx == 4'd9);
    assign ready      = !r_busy || w_byte_end;
    assign tx         = r_tx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 4'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
        end else if (go && ready) begin
            r_busy     <= 1'b1;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 4'd0;
            r_shift    <= data;
            r_tx       <= 1'b0;
        end else if (w_byte_end) begin
            r_busy     <= 1'b0;
            r_baud_cnt <= 16'd0;
            r_tx       <= 1'b1;
        end else if (w_bit_end) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= r_bit_idx + 4'd1;
            // Bit index i+1 carries data bit i; index 9 is the stop bit.
            r_tx       <= (r_bit_idx == 4'd8) ? 1'b1 : r_shift[r_bit_idx[2:0]];
        end else if (r_busy) begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sm_regdump.sv
// Sweeps sm_cpu registers 0..31 over the debug port and streams each word
// out as 8N1 UART bytes, MSB byte first. SM_REGDUMP_ADDR_EN prefixes an address byte.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  idleAddr,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    rd_state_t   r_state, w_state_next;
    logic [4:0]  r_addr, w_addr_next;
    logic [2:0]  r_byte_idx, w_byte_idx_next;
    logic [31:0] r_word, w_word_next;
    logic        r_done, w_done_next;
    logic        w_go;
    logic        w_ready;
    logic [2:0]  w_sel;
    logic [31:0] w_word_src;
    logic [7:0]  w_tx_data;

    // The first byte is issued from the live regData on the SAMPLE edge.
    assign w_word_src = (r_state == RD_SAMPLE) ? regData : r_word;
    assign w_sel      = (r_state == RD_SAMPLE) ? 3'd0 : (r_byte_idx + 3'd1);

`ifdef SM_REGDUMP_ADDR_EN
    assign w_tx_data = (w_sel == 3'd0) ? {3'b000, r_addr}
                                       : rd_word_byte(w_word_src, w_sel - 3'd1);
`else
    assign w_tx_data = rd_word_byte(w_word_src, w_sel);
`endif

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_byte_idx_next = r_byte_idx;
        w_word_next     = r_word;
        w_done_next     = 1'b0;
        w_go            = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (start) begin
                    w_addr_next  = 5'd0;
                    w_state_next = RD_SAMPLE;
                end
            end
            RD_SAMPLE: begin
                w_word_next     = regData;
                w_byte_idx_next = 3'd0;
                w_go            = 1'b1;
                w_state_next    = RD_SEND;
            end
            RD_SEND: begin
                if (w_ready) begin
                    if (r_byte_idx == RD_LAST_BYTE) begin
                        if (r_addr == RD_LAST_REG) begin
                            w_state_next = RD_IDLE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_addr_next  = r_addr + 5'd1;
                            w_state_next = RD_SAMPLE;
                        end
                    end else begin
                        w_go            = 1'b1;
                        w_byte_idx_next = r_byte_idx + 3'd1;
                    end
                end
            end
            default: w_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RD_IDLE;
            r_addr     <= 5'd0;
            r_byte_idx <= 3'd0;
            r_word     <= 32'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_byte_idx <= w_byte_idx_next;
            r_word     <= w_word_next;
            r_done     <= w_done_next;
        end
    end

    sm_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (w_go),
        .data  (w_tx_data),
        .tx    (tx),
        .ready (w_ready)
    );

    assign regAddr = (r_state == RD_IDLE) ? idleAddr : r_addr;
    assign busy    = (r_state != RD_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_sm_regdump.sv
// Scoreboard bench for sm_regdump: a UART decoder on tx pops expected bytes
// pushed from a register-file model when each dump is launched.
module tb_sm_regdump;

    localparam int B = 4;
`ifdef SM_REGDUMP_ADDR_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int WORD_CYC = 1 + NB * 10 * B;
    localparam int EXP_CYC  = 32 * WORD_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  idleAddr = 5'd2;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx, busy, done;

    logic [31:0] rf [32];
    assign regData = rf[regAddr];

    sm_regdump #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .idleAddr (idleAddr),
        .regAddr  (regAddr),
        .regData  (regData),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int byte_cnt = 0;
    int exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected byte stream of a whole dump, straight from the register model.
    task automatic push_dump();
        for (int r = 0; r < 32; r++) begin
            if (NB == 5) exp_q.push_back(r);
            for (int k = 0; k < 4; k++)
                exp_q.push_back(int'((rf[r] >> (24 - 8 * k)) & 32'hFF));
        end
    endtask

    // UART monitor: every cycle of each bit must hold one level.
    int         dec_off = -1;
    logic [9:0] dec_bits;
    logic       dec_bad;
    always @(negedge clk) begin
        if (!rst_n) begin
            dec_off = -1;
        end else begin
            if (dec_off < 0 && tx === 1'b0) begin
                dec_off = 0;
                dec_bad = 1'b0;
            end
            if (dec_off >= 0) begin
                if (dec_off % B == 0) dec_bits[dec_off / B] = tx;
                else if (dec_bits[dec_off / B] !== tx) dec_bad = 1'b1;
                if (dec_off == 10 * B - 1) begin
                    chk($sformatf("frame%0d", byte_cnt), {29'd0, dec_bad, dec_bits[0], dec_bits[9]}, 32'b001);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", dec_bits[8:1]);
                    end else begin
                        chk($sformatf("byte%0d", byte_cnt), {24'd0, dec_bits[8:1]}, exp_q.pop_front());
                    end
                    $display("byte %0d: 0x%02h", byte_cnt, dec_bits[8:1]);
                    byte_cnt++;
                    dec_off = -1;
                end else begin
                    dec_off++;
                end
            end
        end
    end

    task automatic do_dump(input int pulse_at);
        int n;
        int b0;
        b0 = byte_cnt;
        push_dump();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        chk("busy_after_E0", {31'd0, busy}, 32'd1);
        chk("regAddr_first", {27'd0, regAddr}, 32'd0);
        while (done !== 1'b1 && n < EXP_CYC + 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == pulse_at) start = 1'b1;
            if (n == pulse_at + 3) start = 1'b0;
        end
        chk("done_cycles", n, EXP_CYC);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("regAddr_idle", {27'd0, regAddr}, {27'd0, idleAddr});
        chk("byte_count", byte_cnt - b0, 32 * NB);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("tx_idle", {31'd0, tx}, 32'd1);
        $display("dump done after %0d cycles, %0d bytes", n, byte_cnt - b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_regAddr", {27'd0, regAddr}, 32'd2);
        @(posedge clk);
        #1;

        // Random file with a known pattern in register 1.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'h12345678;
        idleAddr = 5'($urandom_range(0, 31));
        do_dump(0);

        // Sweep pattern, with a start pulse in the middle that must be ignored.
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
        do_dump(2000);

        // Reset while register 5, byte 2 is on the line.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        push_dump();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5 * WORD_CYC + 1 + 2 * 10 * B + 5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_regAddr", {27'd0, regAddr}, {27'd0, idleAddr});
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        idleAddr = 5'($urandom_range(0, 31));
        do_dump(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
